// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 8-bit ALU that reads two operands from an external
// register bank, computes one of eight operations and writes the result back.
//
// Each command walks Idle -> RdA -> RdB -> Exec -> Wb, one cycle per state.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   cmd_valid/ready    command handshake; ready only in Idle
//   cmd_op/rd/rs1/rs2  opcode, destination and source register addresses
//   rb_read_addr/data  bank read port (bank answers combinationally)
//   rb_we/write_addr/
//   rb_write_data      bank write port, active only in Wb
//   done               one-cycle pulse coincident with the write-back
//   flag_z, flag_c     zero and carry/borrow of the last executed operation
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_rd,
  input  logic [2:0] cmd_rs1,
  input  logic [2:0] cmd_rs2,
  output logic [2:0] rb_read_addr,
  input  logic [7:0] rb_read_data,
  output logic       rb_we,
  output logic [2:0] rb_write_addr,
  output logic [7:0] rb_write_data,
  output logic       done,
  output logic       flag_z,
  output logic       flag_c
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpMov = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StExec,
    StWb
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, rd_q, rs1_q, rs2_q;
  logic [7:0] a_q, b_q, res_q;
  logic       flag_z_q, flag_c_q;

  logic [7:0] alu_res;
  logic       alu_c;
  logic [8:0] sum9;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StRdA;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Combinational ALU on the captured operands
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    sum9    = {1'b0, a_q} + {1'b0, b_q};
    unique case (op_q)
      OpAdd: begin
        alu_res = sum9[7:0];
        alu_c   = sum9[8];
      end
      OpSub: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpShl: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      OpMov: alu_res = b_q;
      default: alu_res = 8'h00;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      rd_q     <= 3'd0;
      rs1_q    <= 3'd0;
      rs2_q    <= 3'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      res_q    <= 8'h00;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cmd_valid) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
      end
      if (state_q == StRdA) a_q <= rb_read_data;
      if (state_q == StRdB) b_q <= rb_read_data;
      // Flags only move here, so they hold across the idle gap between commands
      if (state_q == StExec) begin
        res_q    <= alu_res;
        flag_z_q <= (alu_res == 8'h00);
        flag_c_q <= alu_c;
      end
    end
  end

  // Outputs are decoded from the current state only
  always_comb begin
    cmd_ready     = 1'b0;
    rb_read_addr  = 3'd0;
    rb_we         = 1'b0;
    rb_write_addr = 3'd0;
    rb_write_data = 8'h00;
    done          = 1'b0;
    unique case (state_q)
      StIdle: cmd_ready = 1'b1;
      StRdA:  rb_read_addr = rs1_q;
      StRdB:  rb_read_addr = rs2_q;
      StExec: ;
      StWb: begin
        rb_we         = 1'b1;
        rb_write_addr = rd_q;
        rb_write_data = res_q;
        done          = 1'b1;
      end
      default: ;
    endcase
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] MOV = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic [2:0] rb_read_addr;
  logic [7:0] rb_read_data;
  logic       rb_we;
  logic [2:0] rb_write_addr;
  logic [7:0] rb_write_data;
  logic       done, flag_z, flag_c;

  int errors = 0;
  int checks = 0;

  // Bench register bank with combinational read and a preload port
  logic [7:0] bank [8] = '{default: 8'h00};
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = 3'd0;
  logic [7:0] pre_data = 8'h00;

  assign rb_read_data = bank[rb_read_addr];

  always @(posedge clk) begin
    if (rb_we) bank[rb_write_addr] <= rb_write_data;
    else if (pre_we) bank[pre_addr] <= pre_data;
  end

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .rb_read_addr (rb_read_addr),
    .rb_read_data (rb_read_data),
    .rb_we        (rb_we),
    .rb_write_addr(rb_write_addr),
    .rb_write_data(rb_write_data),
    .done         (done),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       z;
    logic       c;
  } wb_t;

  wb_t exp_q[$];

  typedef struct {
    logic       pre;
    logic [2:0] pa;
    logic [7:0] pv;
    logic [2:0] pb;
    logic [7:0] pw;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] exp;
    logic       ez;
    logic       ec;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write-back must match the oldest outstanding expectation
  always @(negedge clk) begin
    wb_t e;
    if (done !== rb_we) begin
      checks++;
      errors++;
      $display("FAIL done_vs_we: done=%b rb_we=%b (t=%0t)", done, rb_we, $time);
    end
    if (rb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h expected no write (t=%0t)",
                 rb_write_addr, rb_write_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", 32'(rb_write_addr), 32'(e.addr));
        chk("wb_data", 32'(rb_write_data), 32'(e.data));
        chk("wb_flag_z", 32'(flag_z), 32'(e.z));
        chk("wb_flag_c", 32'(flag_c), 32'(e.c));
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one command and check read addresses, write-back latency and release
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2);
    int k;
    @(negedge clk);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_valid = 1'b1;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("read_addr_rs1", 32'(rb_read_addr), 32'(rs1));
      if (k == 2) chk("read_addr_rs2", 32'(rb_read_addr), 32'(rs2));
      if (k == 3) chk("read_addr_exec", 32'(rb_read_addr), 32'd0);
      if (rb_we === 1'b1) break;
    end
    chk("wb_latency", 32'(k), 32'd4);
    @(negedge clk);
    chk("we_single_cycle", 32'(rb_we), 32'd0);
    chk("ready_after_wb", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    vecs[0]  = '{1'b1, 3'd1, 8'h7F, 3'd2, 8'h01, ADD, 3'd3, 3'd1, 3'd2, 8'h80, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd1, 8'hFF, 3'd2, 8'h01, ADD, 3'd1, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 3'd4, 8'h05, 3'd5, 8'h09, SUB, 3'd6, 3'd4, 3'd5, 8'hFC, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, SHL, 3'd6, 3'd6, 3'd0, 8'hF8, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 3'd2, 8'hF0, 3'd3, 8'h3C, AND, 3'd5, 3'd2, 3'd3, 8'h30, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, OR,  3'd5, 3'd2, 3'd3, 8'hFC, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, XOR, 3'd5, 3'd2, 3'd3, 8'hCC, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, NOT, 3'd4, 3'd3, 3'd0, 8'hC3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, SUB, 3'd7, 3'd2, 3'd2, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, ADD, 3'd2, 3'd2, 3'd3, 8'h2C, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00, SHL, 3'd3, 3'd3, 3'd0, 8'h78, 1'b0, 1'b0};

    // Reset with a command pending: reset must win
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = ADD;
    cmd_rd    = 3'd5;
    cmd_rs1   = 3'd1;
    cmd_rs2   = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rb_we", 32'(rb_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_addr", 32'(rb_read_addr), 32'd0);
    chk("rst_write_addr", 32'(rb_write_addr), 32'd0);
    chk("rst_write_data", 32'(rb_write_data), 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_flag_c", 32'(flag_c), 32'd0);

    // Table-driven single commands
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pre) begin
        preload(vecs[i].pa, vecs[i].pv);
        preload(vecs[i].pb, vecs[i].pw);
      end
      exp_q.push_back('{vecs[i].rd, vecs[i].exp, vecs[i].ez, vecs[i].ec});
      do_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      chk("bank_after_vec", 32'(bank[vecs[i].rd]), 32'(vecs[i].exp));
    end

    // Back-to-back with cmd_valid held high; second reads what the first wrote
    preload(3'd7, 8'hA5);
    exp_q.push_back('{3'd0, 8'hA5, 1'b0, 1'b0});
    exp_q.push_back('{3'd0, 8'h00, 1'b1, 1'b0});
    @(negedge clk);
    cmd_op    = MOV;
    cmd_rd    = 3'd0;
    cmd_rs1   = 3'd0;
    cmd_rs2   = 3'd7;
    cmd_valid = 1'b1;
    chk("b2b_ready_start", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_op  = XOR;
    cmd_rs1 = 3'd0;
    cmd_rs2 = 3'd7;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      lows++;
    end
    chk("b2b_ready_low_1", 32'(lows), 32'd4);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      lows++;
    end
    chk("b2b_ready_low_2", 32'(lows), 32'd4);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_bank_r0", 32'(bank[0]), 32'h00);

    // Reset while in Exec: the command is dropped
    preload(3'd1, 8'h11);
    preload(3'd2, 8'h22);
    @(negedge clk);
    cmd_op    = ADD;
    cmd_rd    = 3'd3;
    cmd_rs1   = 3'd1;
    cmd_rs2   = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_flag_hold", 32'(flag_z), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_we", 32'(rb_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flag_z", 32'(flag_z), 32'd0);
    chk("abort_flag_c", 32'(flag_c), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_bank_r3", 32'(bank[3]), 32'h78);
    exp_q.push_back('{3'd3, 8'h33, 1'b0, 1'b0});
    do_cmd(ADD, 3'd3, 3'd1, 3'd2);
    chk("post_abort_bank_r3", 32'(bank[3]), 32'h33);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
